// File: rtl/ram_load.sv
// ram_load: load-side data-memory unit that reads one or two RAM words and returns the
// extended byte/halfword/word. Define RAM_LOAD_MISALIGNED_EN to service word-crossing loads.
module ram_load #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic [1:0]       memtype_i,
    input  logic             unsigned_i,
    input  logic [WIDTH-1:0] a_i,
    output logic             ready_o,
    output logic             mem_re_o,
    output logic [WIDTH-1:0] mem_a_o,
    input  logic [WIDTH-1:0] mem_rd_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rd_o,
    output logic             fault_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        CAP0   = 3'd2,
`ifdef RAM_LOAD_MISALIGNED_EN
        ISSUE1 = 3'd3,
        CAP1   = 3'd4,
`endif
        RESP   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   addr_q;
    logic [1:0]         memtype_q;
    logic               unsigned_q;
    logic [WIDTH-1:0]   mem_a_q;
    logic [WIDTH-1:0]   rd_q;
    logic [WIDTH-1:0]   rd_next;
    logic [2*WIDTH-1:0] pair;

    // An access crosses a word boundary when its last byte lands in the next word.
    function automatic logic is_crossing(input logic [1:0] mt, input logic [1:0] lsb);
        case (mt)
            2'b01:   is_crossing = 1'b0;
            2'b10:   is_crossing = (lsb == 2'b11);
            default: is_crossing = (lsb != 2'b00);
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] extract(input logic [2*WIDTH-1:0] p,
                                                 input logic [1:0] lsb,
                                                 input logic [1:0] mt,
                                                 input logic uns);
        logic [WIDTH-1:0] s;
        s = WIDTH'(p >> {lsb, 3'b000});
        case (mt)
            2'b01:   extract = uns ? {{(WIDTH-8){1'b0}}, s[7:0]}
                               : {{(WIDTH-8){s[7]}}, s[7:0]};
            2'b10:   extract = uns ? {{(WIDTH-16){1'b0}}, s[15:0]}
                               : {{(WIDTH-16){s[15]}}, s[15:0]};
            default: extract = s;
        endcase
    endfunction

`ifdef RAM_LOAD_MISALIGNED_EN
    logic [WIDTH-1:0] lo_q;
    logic             cross_q;
    assign cross_q = is_crossing(memtype_q, addr_q[1:0]);
`else
    logic             fault_q;
    logic             cross_in;
    assign cross_in = is_crossing(memtype_i, a_i[1:0]);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
`ifdef RAM_LOAD_MISALIGNED_EN
                    state_d = ISSUE0;
`else
                    state_d = cross_in ? RESP : ISSUE0;
`endif
                end
            end
            ISSUE0: state_d = CAP0;
`ifdef RAM_LOAD_MISALIGNED_EN
            CAP0:   state_d = cross_q ? ISSUE1 : RESP;
            ISSUE1: state_d = CAP1;
            CAP1:   state_d = RESP;
`else
            CAP0:   state_d = RESP;
`endif
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o  = 1'b0;
        mem_re_o = 1'b0;
        valid_o  = 1'b0;
        case (state_q)
            IDLE:   ready_o  = 1'b1;
            ISSUE0: mem_re_o = 1'b1;
`ifdef RAM_LOAD_MISALIGNED_EN
            ISSUE1: mem_re_o = 1'b1;
`endif
            RESP:   valid_o  = 1'b1;
            default: ;
        endcase
    end

    // The upper word only carries real data while the second read is being captured.
    always_comb begin
`ifdef RAM_LOAD_MISALIGNED_EN
        if (state_q == CAP1) begin
            pair = {mem_rd_i, lo_q};
        end else begin
            pair = {{WIDTH{1'b0}}, mem_rd_i};
        end
`else
        pair = {{WIDTH{1'b0}}, mem_rd_i};
`endif
        rd_next = extract(pair, addr_q[1:0], memtype_q, unsigned_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            memtype_q  <= '0;
            unsigned_q <= 1'b0;
            mem_a_q    <= '0;
            rd_q       <= '0;
`ifdef RAM_LOAD_MISALIGNED_EN
            lo_q       <= '0;
`else
            fault_q    <= 1'b0;
`endif
        end else begin
            if (state_q == IDLE && req_i) begin
                addr_q     <= a_i;
                memtype_q  <= memtype_i;
                unsigned_q <= unsigned_i;
            end
            if (state_q == IDLE && state_d == ISSUE0) begin
                mem_a_q <= {a_i[WIDTH-1:2], 2'b00};
            end
`ifdef RAM_LOAD_MISALIGNED_EN
            if (state_q == CAP0) begin
                lo_q <= mem_rd_i;
            end
            if (state_d == ISSUE1) begin
                mem_a_q <= {addr_q[WIDTH-1:2] + (WIDTH-2)'(1), 2'b00};
            end
            if (state_d == RESP) begin
                rd_q <= rd_next;
            end
`else
            // Jumping straight from IDLE to RESP is the misaligned-fault path.
            if (state_d == RESP) begin
                if (state_q == IDLE) begin
                    rd_q    <= '0;
                    fault_q <= 1'b1;
                end else begin
                    rd_q    <= rd_next;
                    fault_q <= 1'b0;
                end
            end
`endif
        end
    end

    assign mem_a_o = mem_a_q;
    assign rd_o    = rd_q;
`ifdef RAM_LOAD_MISALIGNED_EN
    assign fault_o = 1'b0;
`else
    assign fault_o = fault_q & valid_o;
`endif

endmodule

// File: tb/tb_ram_load.sv
// tb_ram_load: randomized self-checking bench for ram_load against a byte-addressed
// memory model; follows RAM_LOAD_MISALIGNED_EN the same way the design does.
module tb_ram_load;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic [1:0]  memtype_i;
    logic        unsigned_i;
    logic [31:0] a_i;
    logic        ready_o;
    logic        mem_re_o;
    logic [31:0] mem_a_o;
    logic [31:0] mem_rd_i = 32'h0;
    logic        valid_o;
    logic [31:0] rd_o;
    logic        fault_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [logic [31:0]];

    always #5 clk_i = ~clk_i;

    ram_load #(.WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .memtype_i  (memtype_i),
        .unsigned_i (unsigned_i),
        .a_i        (a_i),
        .ready_o    (ready_o),
        .mem_re_o   (mem_re_o),
        .mem_a_o    (mem_a_o),
        .mem_rd_i   (mem_rd_i),
        .valid_o    (valid_o),
        .rd_o       (rd_o),
        .fault_o    (fault_o)
    );

    function automatic logic [31:0] word_at(input logic [31:0] wa);
        if (ram.exists(wa)) return ram[wa];
        return (wa * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    // Synchronous RAM: data appears the cycle after a strobe, garbage otherwise.
    always @(posedge clk_i) begin
        if (mem_re_o) mem_rd_i <= word_at(mem_a_o);
        else          mem_rd_i <= $urandom;
    end

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = word_at({a[31:2], 2'b00});
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    function automatic int size_of(input logic [1:0] mt);
        if (mt == 2'b01) return 1;
        if (mt == 2'b10) return 2;
        return 4;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] mt, input logic uns);
        int          n;
        int          lat;
        int          exp_lat;
        logic        crossing;
        logic        exp_fault;
        logic [31:0] exp_rd;
        logic [31:0] base;
        logic [31:0] reads[$];
        logic [31:0] exp_reads[$];
        string       ctx;

        ctx      = $sformatf("a=%h mt=%0d u=%0d", addr, mt, uns);
        n        = size_of(mt);
        base     = {addr[31:2], 2'b00};
        crossing = (int'(addr[1:0]) + n) > 4;
        exp_rd   = 32'h0;
        for (int i = 0; i < n; i++) begin
            exp_rd |= 32'(byte_at(addr + 32'(i))) << (8 * i);
        end
        if (n < 4 && !uns && exp_rd[8*n-1]) begin
            exp_rd |= ~((32'd1 << (8 * n)) - 32'd1);
        end
        exp_fault = 1'b0;
        exp_lat   = 3;
        exp_reads.push_back(base);
        if (crossing) begin
`ifdef RAM_LOAD_MISALIGNED_EN
            exp_reads.push_back(base + 32'd4);
            exp_lat = 5;
`else
            exp_reads.delete();
            exp_fault = 1'b1;
            exp_rd    = 32'h0;
            exp_lat   = 1;
`endif
        end

        for (int k = 0; k < 20 && ready_o !== 1'b1; k++) @(negedge clk_i);
        checkOutput({"ready_before_req ", ctx}, 32'(ready_o), 32'd1);
        @(negedge clk_i);
        a_i        = addr;
        memtype_i  = mt;
        unsigned_i = uns;
        req_i      = 1'b1;
        @(posedge clk_i);
        #1;
        req_i      = 1'b0;
        a_i        = $urandom;
        memtype_i  = 2'($urandom);
        unsigned_i = 1'($urandom);

        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_re_o === 1'b1) reads.push_back(mem_a_o);
            if (valid_o === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        checkOutput({"latency ", ctx}, 32'(lat), 32'(exp_lat));
        checkOutput({"rd_o ", ctx}, rd_o, exp_rd);
        checkOutput({"fault_o ", ctx}, 32'(fault_o), 32'(exp_fault));
        checkOutput({"read_count ", ctx}, 32'(reads.size()), 32'(exp_reads.size()));
        for (int i = 0; i < reads.size() && i < exp_reads.size(); i++) begin
            checkOutput({"read_addr ", ctx}, reads[i], exp_reads[i]);
        end

        @(posedge clk_i);
        #1;
        checkOutput({"valid_pulse ", ctx}, 32'(valid_o), 32'd0);
        checkOutput({"rd_hold ", ctx}, rd_o, exp_rd);
        checkOutput({"ready_after ", ctx}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        int          vcount;
        logic [31:0] addr;

        rst_ni     = 1'b0;
        req_i      = 1'b0;
        a_i        = 32'h0;
        memtype_i  = 2'b00;
        unsigned_i = 1'b0;
        ram[32'h100] = 32'h80FF7F01;
        ram[32'h104] = 32'h44332211;
        for (int w = 0; w < 16; w++) ram[32'h200 + 32'(4 * w)] = $urandom;

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset_ready", 32'(ready_o), 32'd1);
        checkOutput("reset_valid", 32'(valid_o), 32'd0);
        checkOutput("reset_mem_re", 32'(mem_re_o), 32'd0);
        checkOutput("reset_fault", 32'(fault_o), 32'd0);
        checkOutput("reset_rd", rd_o, 32'h0);
        checkOutput("reset_mem_a", mem_a_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        applyStimulus(32'h101, 2'b01, 1'b0);
        checkOutput("lb_101", rd_o, 32'h0000007F);
        applyStimulus(32'h102, 2'b01, 1'b0);
        checkOutput("lb_102", rd_o, 32'hFFFFFFFF);
        applyStimulus(32'h102, 2'b01, 1'b1);
        checkOutput("lbu_102", rd_o, 32'h000000FF);
        applyStimulus(32'h102, 2'b10, 1'b0);
        checkOutput("lh_102", rd_o, 32'hFFFF80FF);
        applyStimulus(32'h102, 2'b10, 1'b1);
        checkOutput("lhu_102", rd_o, 32'h000080FF);
        applyStimulus(32'h100, 2'b00, 1'b0);
        checkOutput("lw_100", rd_o, 32'h80FF7F01);
        applyStimulus(32'h100, 2'b11, 1'b1);
        checkOutput("lw11_100", rd_o, 32'h80FF7F01);
        applyStimulus(32'h103, 2'b00, 1'b0);
`ifdef RAM_LOAD_MISALIGNED_EN
        checkOutput("lw_103", rd_o, 32'h33221180);
`else
        checkOutput("lw_103", rd_o, 32'h00000000);
`endif
        applyStimulus(32'h103, 2'b10, 1'b0);
`ifdef RAM_LOAD_MISALIGNED_EN
        checkOutput("lh_103", rd_o, 32'h00001180);
`else
        checkOutput("lh_103", rd_o, 32'h00000000);
`endif
        applyStimulus(32'hFFFFFFFD, 2'b00, 1'b0);
        applyStimulus(32'hFFFFFFFF, 2'b10, 1'b1);

        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 2))
                0:       addr = 32'h200 + 32'($urandom_range(0, 63));
                1:       addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
                default: addr = $urandom;
            endcase
            applyStimulus(addr, 2'($urandom_range(0, 3)), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        // Reset while the first read's data is being captured.
        for (int k = 0; k < 20 && ready_o !== 1'b1; k++) @(negedge clk_i);
        @(negedge clk_i);
        a_i       = 32'h100;
        memtype_i = 2'b00;
        req_i     = 1'b1;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        checkOutput("midrst_issue0_re", 32'(mem_re_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("midrst_ready", 32'(ready_o), 32'd1);
        checkOutput("midrst_valid", 32'(valid_o), 32'd0);
        checkOutput("midrst_mem_re", 32'(mem_re_o), 32'd0);
        checkOutput("midrst_mem_a", mem_a_o, 32'h0);
        checkOutput("midrst_rd", rd_o, 32'h0);
        checkOutput("midrst_fault", 32'(fault_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i);
            #1;
            if (valid_o === 1'b1) vcount++;
        end
        checkOutput("midrst_no_valid", 32'(vcount), 32'd0);
        checkOutput("midrst_ready_after", 32'(ready_o), 32'd1);
        applyStimulus(32'h104, 2'b00, 1'b0);
        checkOutput("lw_104_after_reset", rd_o, 32'h44332211);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
